seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/mult_pkg.sv | 13 +
 rtl/twos_negate.sv | 12 +
 rtl/seq_multiplier.sv | 116 +++++++++++
 tb/tb_seq_multiplier.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Iteration counter must hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negation, used both for operand magnitude and result sign.
module twos_negate #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-and-add multiplier with sign-magnitude handling and valid/ready handshakes.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  logic [1:0]       state_q,  state_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             sign_q,   sign_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    z_corr;

  twos_negate #(.W(WIDTH)) u_neg_a (
    .x   (a),
    .neg (is_signed & a[WIDTH-1]),
    .y   (a_mag)
  );

  twos_negate #(.W(WIDTH)) u_neg_b (
    .x   (b),
    .neg (is_signed & b[WIDTH-1]),
    .y   (b_mag)
  );

  twos_negate #(.W(PW)) u_neg_z (
    .x   (acc_q),
    .neg (sign_q),
    .y   (z_corr)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          sign_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          // The final partial product lands on the same edge that enters DONE.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign z         = out_valid ? z_corr : '0;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks of seq_multiplier at WIDTH=8.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    logic signed [15:0] sa, sb, sp;
    if (sv) begin
      sa = {{8{av[7]}}, av};
      sb = {{8{bv[7]}}, bv};
      sp = sa * sb;
      return sp;
    end
    return {8'd0, av} * {8'd0, bv};
  endfunction

  // Starts in IDLE; accepts on the next edge, waits for the product, applies bp cycles of
  // backpressure (with in_valid/abort asserted, both must be ignored), then drains.
  task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic [15:0] exp, input int bp, input logic abort_in);
    int cyc;
    int busy_n;
    logic [15:0] zhold;
    a = av; b = bv; is_signed = sv; in_valid = 1'b1; abort = abort_in;
    @(posedge clk); #1;
    abort = 1'b0;
    a = ~av; b = bv ^ 8'h5a; is_signed = ~sv;
    cyc = 0; busy_n = 0;
    while (!out_valid && cyc < 40) begin
      if (busy) busy_n++;
      check_eq({name, " z_run"}, 32'(z), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq({name, " latency"}, 32'(cyc), 32'd8);
    check_eq({name, " busy_cycles"}, 32'(busy_n), 32'd8);
    check_eq({name, " z"}, 32'(z), 32'(exp));
    zhold = z;
    in_valid = 1'b1;
    for (int i = 0; i < bp; i++) begin
      abort = 1'b1;
      @(posedge clk); #1;
      check_eq({name, " z_hold"}, 32'(z), 32'(zhold));
      check_eq({name, " out_valid_hold"}, 32'(out_valid), 32'd1);
      check_eq({name, " in_ready_hold"}, 32'(in_ready), 32'd0);
    end
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({name, " in_ready_after"}, 32'(in_ready), 32'd1);
    check_eq({name, " out_valid_after"}, 32'(out_valid), 32'd0);
    check_eq({name, " z_idle"}, 32'(z), 32'd0);
    $display("%s: a=0x%02h b=0x%02h signed=%0d z=0x%04h exp=0x%04h latency=%0d bp=%0d",
             name, av, bv, sv, zhold, exp, cyc, bp);
  endtask

  initial begin
    int ov_seen;
    logic [7:0] ra, rb;
    logic rs;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    #2;
    check_eq("reset in_ready", 32'(in_ready), 32'd1);
    check_eq("reset out_valid", 32'(out_valid), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset z", 32'(z), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    run_op("u255x255", 8'hff, 8'hff, 1'b0, 16'hfe01, 0, 1'b0);
    run_op("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000, 1, 1'b0);
    run_op("s-1x127", 8'hff, 8'h7f, 1'b1, 16'hff81, 0, 1'b0);
    run_op("s0x-5", 8'h00, 8'hfb, 1'b1, 16'h0000, 0, 1'b0);
    run_op("u200x3_bp5", 8'd200, 8'd3, 1'b0, 16'd600, 5, 1'b0);
    run_op("s-7x9", 8'hf9, 8'd9, 1'b1, 16'hffc1, 2, 1'b0);

    // Abort during the third RUN cycle.
    a = 8'd5; b = 8'd6; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort in_ready", 32'(in_ready), 32'd1);
    ov_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) ov_seen++;
      @(posedge clk); #1;
    end
    check_eq("abort no_out_valid", 32'(ov_seen), 32'd0);
    $display("abort: 5x6 cancelled in RUN, out_valid pulses=%0d", ov_seen);
    run_op("3x4_with_abort_in_idle", 8'd3, 8'd4, 1'b0, 16'd12, 0, 1'b1);

    // Asynchronous reset mid-RUN.
    a = 8'd7; b = 8'd9; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst in_ready", 32'(in_ready), 32'd1);
    check_eq("async_rst busy", 32'(busy), 32'd0);
    check_eq("async_rst out_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst z", 32'(z), 32'd0);
    $display("async_rst: reset asserted mid-RUN of 7x9");
    @(negedge clk); rst_n = 1'b1;
    run_op("10x10_after_rst", 8'd10, 8'd10, 1'b0, 16'd100, 0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i % 50 == 0) ra = 8'h80;
      if (i % 70 == 0) rb = 8'h80;
      run_op("rand", ra, rb, rs, ref_mul(ra, rb, rs), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
